// File: rtl/ct_mmu_jtlb_tag_ctrl.sv
// JTLB tag array access controller: lookup compare, FIFO-victim refill
// and invalidate-all sweep, all arbitrated from a single IDLE state.
module ct_mmu_jtlb_tag_ctrl #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 47
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             lk_req_vld,
    input  logic [IDX_W-1:0] lk_req_idx,
    input  logic [TAG_W-1:0] lk_req_tag,
    output logic             lk_req_rdy,
    output logic             lk_rsp_vld,
    output logic             lk_rsp_hit,
    output logic [3:0]       lk_rsp_way,
    input  logic             rf_req_vld,
    input  logic [IDX_W-1:0] rf_req_idx,
    input  logic [47:0]      rf_req_entry,
    output logic             rf_req_rdy,
    output logic             rf_done,
    output logic [3:0]       rf_done_way,
    input  logic             inv_all_req,
    output logic             inv_all_done,
    output logic             jtlb_tag_cen,
    output logic [IDX_W-1:0] jtlb_tag_idx,
    output logic [4:0]       jtlb_tag_wen,
    output logic [195:0]     jtlb_tag_din,
    input  logic [195:0]     jtlb_tag_dout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LK_CMP = 3'd1;
    localparam logic [2:0] RF_SEL = 3'd2;
    localparam logic [2:0] RF_WR  = 3'd3;
    localparam logic [2:0] INV    = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] inv_cnt;
    logic             inv_last;
    logic [IDX_W-1:0] rf_idx;
    logic [47:0]      rf_entry;
    logic [3:0]       rf_victim;
    logic [3:0]       rf_fifo;
    logic [TAG_W-1:0] lk_tag;

    logic             is_idle;
    logic             lk_acc;
    logic             rf_acc;
    logic             inv_acc;

    logic [3:0]       way_vld;
    logic [3:0]       way_hit;
    logic [3:0]       way_free;
    logic [3:0]       free_low;
    logic [3:0]       fifo_cur;
    logic             fifo_oh;
    logic [3:0]       victim;
    logic [3:0]       fifo_nxt;

    assign is_idle    = (state == IDLE);
    assign rf_req_rdy = is_idle & ~inv_all_req;
    assign lk_req_rdy = is_idle & ~inv_all_req & ~rf_req_vld;
    assign inv_acc    = is_idle & inv_all_req;
    assign rf_acc     = rf_req_rdy & rf_req_vld;
    assign lk_acc     = lk_req_rdy & lk_req_vld;
    assign inv_last   = (inv_cnt == {IDX_W{1'b1}});

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            way_vld[n] = jtlb_tag_dout[48*n+47];
            way_hit[n] = way_vld[n]
                       & (jtlb_tag_dout[48*n +: TAG_W] == lk_tag);
        end
    end

    // Invalid ways are filled first; the FIFO pointer only picks among full sets.
    assign way_free = ~way_vld;
    assign free_low = way_free & (~way_free + 4'd1);
    assign fifo_cur = jtlb_tag_dout[195:192];
    assign fifo_oh  = (fifo_cur != 4'd0)
                    && ((fifo_cur & (fifo_cur - 4'd1)) == 4'd0);

    always_comb begin
        victim   = 4'b0001;
        fifo_nxt = 4'b0001;
        if (|way_free) begin
            victim   = free_low;
            fifo_nxt = fifo_oh ? fifo_cur : 4'b0001;
        end else if (fifo_oh) begin
            victim   = fifo_cur;
            fifo_nxt = {fifo_cur[2:0], fifo_cur[3]};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (inv_acc)
                    state_nxt = INV;
                else if (rf_acc)
                    state_nxt = RF_SEL;
                else if (lk_acc)
                    state_nxt = LK_CMP;
            end
            LK_CMP: state_nxt = IDLE;
            RF_SEL: state_nxt = RF_WR;
            RF_WR:  state_nxt = IDLE;
            INV:    state_nxt = inv_last ? IDLE : INV;
            default: state_nxt = IDLE;
        endcase
    end

    // Array pins are held quiet while reset is asserted so no write escapes.
    always_comb begin
        jtlb_tag_cen = 1'b0;
        jtlb_tag_idx = '0;
        jtlb_tag_wen = 5'd0;
        jtlb_tag_din = '0;
        if (!cpurst) begin
            unique case (1'b1)
                inv_acc: begin
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_wen = 5'h1F;
                end
                rf_acc: begin
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_idx = rf_req_idx;
                end
                lk_acc: begin
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_idx = lk_req_idx;
                end
                (state == RF_WR): begin
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_idx = rf_idx;
                    jtlb_tag_wen = {1'b1, rf_victim};
                    jtlb_tag_din = {rf_fifo, {4{rf_entry}}};
                end
                (state == INV): begin
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_idx = inv_cnt;
                    jtlb_tag_wen = 5'h1F;
                end
                default: begin
                    jtlb_tag_cen = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state   <= IDLE;
            inv_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (inv_acc)
                inv_cnt <= {{(IDX_W-1){1'b0}}, 1'b1};
            else if (state == INV)
                inv_cnt <= inv_cnt + 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            lk_tag    <= '0;
            rf_idx    <= '0;
            rf_entry  <= '0;
            rf_victim <= 4'd0;
            rf_fifo   <= 4'd0;
        end else begin
            if (lk_acc)
                lk_tag <= lk_req_tag;
            if (rf_acc) begin
                rf_idx   <= rf_req_idx;
                rf_entry <= rf_req_entry;
            end
            if (state == RF_SEL) begin
                rf_victim <= victim;
                rf_fifo   <= fifo_nxt;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            lk_rsp_vld   <= 1'b0;
            lk_rsp_hit   <= 1'b0;
            lk_rsp_way   <= 4'd0;
            rf_done      <= 1'b0;
            rf_done_way  <= 4'd0;
            inv_all_done <= 1'b0;
        end else begin
            lk_rsp_vld   <= (state == LK_CMP);
            rf_done      <= (state == RF_WR);
            inv_all_done <= (state == INV) & inv_last;
            if (state == LK_CMP) begin
                lk_rsp_hit <= |way_hit;
                lk_rsp_way <= way_hit;
            end
            if (state == RF_WR)
                rf_done_way <= rf_victim;
        end
    end

endmodule

// File: tb/tb_ct_mmu_jtlb_tag_ctrl.sv
// Directed bench for the JTLB tag controller with a behavioural
// tag array model behind the array pins.
module tb_ct_mmu_jtlb_tag_ctrl;

    logic         clk = 1'b0;
    logic         cpurst;
    logic         lk_req_vld;
    logic [7:0]   lk_req_idx;
    logic [46:0]  lk_req_tag;
    logic         lk_req_rdy;
    logic         lk_rsp_vld;
    logic         lk_rsp_hit;
    logic [3:0]   lk_rsp_way;
    logic         rf_req_vld;
    logic [7:0]   rf_req_idx;
    logic [47:0]  rf_req_entry;
    logic         rf_req_rdy;
    logic         rf_done;
    logic [3:0]   rf_done_way;
    logic         inv_all_req;
    logic         inv_all_done;
    logic         cen;
    logic [7:0]   idx;
    logic [4:0]   wen;
    logic [195:0] din;
    logic [195:0] dout;

    logic [195:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ct_mmu_jtlb_tag_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst        (cpurst),
        .lk_req_vld    (lk_req_vld),
        .lk_req_idx    (lk_req_idx),
        .lk_req_tag    (lk_req_tag),
        .lk_req_rdy    (lk_req_rdy),
        .lk_rsp_vld    (lk_rsp_vld),
        .lk_rsp_hit    (lk_rsp_hit),
        .lk_rsp_way    (lk_rsp_way),
        .rf_req_vld    (rf_req_vld),
        .rf_req_idx    (rf_req_idx),
        .rf_req_entry  (rf_req_entry),
        .rf_req_rdy    (rf_req_rdy),
        .rf_done       (rf_done),
        .rf_done_way   (rf_done_way),
        .inv_all_req   (inv_all_req),
        .inv_all_done  (inv_all_done),
        .jtlb_tag_cen  (cen),
        .jtlb_tag_idx  (idx),
        .jtlb_tag_wen  (wen),
        .jtlb_tag_din  (din),
        .jtlb_tag_dout (dout)
    );

    always @(posedge clk) begin
        if (cen) begin
            if (wen == 5'd0)
                dout <= mem[idx];
            for (int w = 0; w < 4; w++)
                if (wen[w])
                    mem[idx][48*w +: 48] <= din[48*w +: 48];
            if (wen[4])
                mem[idx][195:192] <= din[195:192];
        end
    end

    task automatic chk(input string tag,
                       input logic [195:0] act,
                       input logic [195:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic inv_sweep(input string name);
        int bad;
        bad = 0;
        inv_all_req = 1'b1;
        #1;
        chk({name, "_acc"}, {cen, wen, idx}, {1'b1, 5'h1F, 8'd0});
        chk({name, "_din"}, din, '0);
        chk({name, "_rdy"}, {lk_req_rdy, rf_req_rdy}, 2'b00);
        @(negedge clk);
        inv_all_req = 1'b0;
        for (int i = 1; i < 256; i++) begin
            if (i > 1)
                @(negedge clk);
            #1;
            if ({cen, wen, idx, lk_req_rdy, rf_req_rdy, inv_all_done}
                !== {1'b1, 5'h1F, 8'(i), 3'b000} || din !== '0)
                bad++;
        end
        chk({name, "_sweep"}, 196'(bad), '0);
    endtask

    task automatic rf(input logic [7:0] ri, input logic [47:0] ent,
                      input logic [3:0] way, input logic [3:0] fifo,
                      input string name);
        rf_req_vld   = 1'b1;
        rf_req_idx   = ri;
        rf_req_entry = ent;
        #1;
        chk({name, "_acc"}, {rf_req_rdy, cen, wen, idx},
            {1'b1, 1'b1, 5'd0, ri});
        @(negedge clk);
        rf_req_vld = 1'b0;
        #1;
        chk({name, "_sel"}, {cen, wen, rf_done}, '0);
        @(negedge clk);
        #1;
        chk({name, "_wr"}, {cen, wen, idx}, {1'b1, 1'b1, way, ri});
        chk({name, "_din"}, din, {fifo, {4{ent}}});
        @(negedge clk);
        #1;
        chk({name, "_done"}, {rf_done, rf_done_way, cen},
            {1'b1, way, 1'b0});
    endtask

    task automatic lk(input logic [7:0] li, input logic [46:0] tag,
                      input logic hit, input logic [3:0] way,
                      input string name);
        lk_req_vld = 1'b1;
        lk_req_idx = li;
        lk_req_tag = tag;
        #1;
        chk({name, "_acc"}, {lk_req_rdy, cen, wen, idx},
            {1'b1, 1'b1, 5'd0, li});
        @(negedge clk);
        lk_req_vld = 1'b0;
        #1;
        chk({name, "_cmp"}, {lk_rsp_vld, cen}, 2'b00);
        @(negedge clk);
        #1;
        chk({name, "_rsp"}, {lk_rsp_vld, lk_rsp_hit, lk_rsp_way},
            {1'b1, hit, way});
    endtask

    logic [3:0]  exp_way  [8];
    logic [3:0]  exp_fifo [8];
    logic [47:0] ent;

    initial begin
        exp_way  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_fifo = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                     4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cpurst       = 1'b1;
        lk_req_vld   = 1'b0;
        lk_req_idx   = '0;
        lk_req_tag   = '0;
        rf_req_vld   = 1'b0;
        rf_req_idx   = '0;
        rf_req_entry = '0;
        inv_all_req  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pins", {cen, wen, idx, din}, '0);
        chk("rst_pulses", {lk_rsp_vld, rf_done, inv_all_done}, 3'b000);
        chk("rst_rsp", {lk_rsp_hit, lk_rsp_way, rf_done_way}, '0);
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        chk("rst_rdy", {lk_req_rdy, rf_req_rdy, cen}, 3'b110);

        inv_sweep("inv");
        @(negedge clk);
        #1;
        chk("inv_done", {inv_all_done, lk_req_rdy, rf_req_rdy, cen},
            4'b1110);
        @(negedge clk);
        #1;
        chk("inv_pulse", inv_all_done, 1'b0);

        rf(8'd5, {1'b1, 47'h1234}, 4'b0001, 4'b0001, "rf5");
        lk(8'd5, 47'h1234, 1'b1, 4'b0001, "lk_hit");
        lk(8'd5, 47'h1235, 1'b0, 4'b0000, "lk_miss");
        lk(8'd5, 47'h0, 1'b0, 4'b0000, "lk_invalid");

        for (int k = 0; k < 8; k++) begin
            ent = {1'b1, 47'h900 + 47'(k == 7 ? 6 : k)};
            rf(8'd9, ent, exp_way[k], exp_fifo[k], $sformatf("rf9_%0d", k));
        end
        lk(8'd9, 47'h906, 1'b1, 4'b1100, "lk_multi");
        lk(8'd9, 47'h904, 1'b1, 4'b0001, "lk_way0");
        lk(8'd9, 47'h900, 1'b0, 4'b0000, "lk_evicted");

        lk_req_vld   = 1'b1;
        lk_req_idx   = 8'd5;
        lk_req_tag   = 47'h1234;
        rf_req_vld   = 1'b1;
        rf_req_idx   = 8'd7;
        rf_req_entry = {1'b1, 47'h777};
        inv_sweep("pri_inv");
        @(negedge clk);
        #1;
        chk("pri_done", {inv_all_done, rf_req_rdy, lk_req_rdy, cen, wen, idx},
            {4'b1101, 5'd0, 8'd7});
        @(negedge clk);
        rf_req_vld = 1'b0;
        #1;
        chk("pri_sel", {lk_req_rdy, cen}, 2'b00);
        @(negedge clk);
        #1;
        chk("pri_wr", {lk_req_rdy, cen, wen, idx},
            {1'b0, 1'b1, 5'b10001, 8'd7});
        @(negedge clk);
        #1;
        chk("pri_lk", {rf_done, lk_req_rdy, cen, wen, idx},
            {3'b111, 5'd0, 8'd5});
        @(negedge clk);
        lk_req_vld = 1'b0;
        @(negedge clk);
        #1;
        chk("pri_rsp", {lk_rsp_vld, lk_rsp_hit, lk_rsp_way}, 6'b100000);

        rf_req_vld   = 1'b1;
        rf_req_idx   = 8'd3;
        rf_req_entry = {1'b1, 47'h333};
        #1;
        chk("rrst_acc", {rf_req_rdy, cen, idx}, {2'b11, 8'd3});
        @(negedge clk);
        rf_req_vld = 1'b0;
        cpurst     = 1'b1;
        #1;
        chk("rrst_sel", {cen, wen}, 6'd0);
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        chk("rrst_idle", {cen, wen, rf_done, rf_req_rdy}, {7'd0, 1'b1});
        @(negedge clk);
        #1;
        chk("rrst_nodone", {rf_done, cen, wen}, 7'd0);
        lk(8'd3, 47'h333, 1'b0, 4'b0000, "rrst_nowrite");
        rf(8'd3, {1'b1, 47'h333}, 4'b0001, 4'b0001, "rf_after_rst");
        lk(8'd3, 47'h333, 1'b1, 4'b0001, "lk_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
